serial_word_loader: RTL and testbench
=====================================

SERIAL_WORD_LOADER -- requirements
Module: serial_word_loader

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the assembled word width; legal range is 2..64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1), SHALL set the bit-count field width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 s_valid  input  1  SHALL mark the serial bit as offered.
REQ-006 s_ready  output  1  SHALL mark the loader as able to accept a bit.
REQ-007 s_bit  input  1  SHALL carry the serial data bit.
REQ-008 s_last  input  1  SHALL mark the accepted bit as the final bit of a frame.
REQ-009 m_valid  output  1  SHALL mark the assembled word as valid; this drives the downstream single-bit strobe input.
REQ-010 m_ready  input  1  SHALL mark the downstream as accepting the word.
REQ-011 m_word  output  WIDTH  SHALL carry the assembled word; this drives the downstream 32-bit bus input.
REQ-012 m_count  output  CNT_W  SHALL carry the number of valid bits in m_word (1..WIDTH).
REQ-013 m_short  output  1  SHALL be high when m_count < WIDTH.

Function
REQ-014 A serial transfer SHALL occur on a cycle with s_valid && s_ready; a word transfer SHALL occur on a cycle with m_valid && m_ready.
REQ-015 Bits SHALL be assembled LSB-first: the k-th accepted bit of a word (k from 0) lands in m_word[k].
REQ-016 Unfilled upper bits of a short word SHALL be zero.
REQ-017 The shift side SHALL have two states: FILL (accepting bits, count 0..WIDTH-1) and FULL (word complete, awaiting the output register).
REQ-018 A word SHALL complete when the accepted bit makes the count equal WIDTH, or when an accepted bit has s_last=1, whichever comes first.
REQ-019 If the count reaches WIDTH without s_last, the word SHALL be emitted with m_short=0, and the next accepted bit SHALL start a new word (no error).
REQ-020 s_last on the WIDTH-th bit SHALL produce a single word with m_short=0, not a following empty word.
REQ-021 The output side SHALL hold one word register (EMPTY/VALID), separate from the shift register.
REQ-022 On completion with the output register EMPTY, or VALID and transferring in the same cycle, the word SHALL move to the output register at that edge; m_valid SHALL rise the cycle after the final bit is accepted (latency 1).
REQ-023 On completion with the output register VALID and not transferring, the shift side SHALL enter FULL; s_ready SHALL be 0 while FULL.
REQ-024 From FULL, the word SHALL move to the output register on the edge of the next word transfer, and the shift side SHALL return to FILL with count 0.
REQ-025 s_ready SHALL be a registered output, depending only on state, not combinationally on m_ready.
REQ-026 m_word, m_count and m_short SHALL be stable while m_valid=1 && m_ready=0.
REQ-027 m_valid SHALL fall after a word transfer unless a new word loads on the same edge, in which case it SHALL stay high with no bubble.
REQ-028 Sustained throughput SHALL be one bit per cycle when m_ready is held at 1.

Reset
REQ-029 Asserting rst SHALL immediately clear the following: m_valid=0, m_word=0, m_count=0, m_short=0, s_ready=0, shift register=0, count=0, shift state=FILL.
REQ-030 s_ready SHALL rise on the first clock edge after rst deasserts.
REQ-031 Reset mid-frame or mid-hold SHALL discard partial and held words with no output pulse.

Structure
REQ-032 The WIDTH default, the CNT_W derivation, and the shift-state enumeration SHALL live in the shared package loader_pkg.
REQ-033 The output word register with its valid/ready logic SHALL be the sub-module word_out_slice (parameterised by WIDTH+CNT_W+1).
REQ-034 The design SHALL use no latches, no combinational paths from input to output, and a single clock domain.

Verification
REQ-035 Reset, then 32 bits of 0xA5A5_F00F LSB-first with m_ready=1 and s_last only on bit 31 -> one word: m_word=0xA5A5F00F, m_count=32, m_short=0, m_valid high for exactly 1 cycle, the cycle after bit 31.
REQ-036 5 bits 1,0,1,1,1 with s_last on bit 4 -> m_word=0x0000001D, m_count=5, m_short=1.
REQ-037 m_ready=0, two full 32-bit words streamed -> second word completes, s_ready=0 (FULL); pulse m_ready=1 for 1 cycle -> first word transfers, second loads with no m_valid bubble, s_ready=1 the next cycle.
REQ-038 64 bits streamed with no s_last -> two words with m_short=0, and bit 32 lands in word 2 bit 0.
REQ-039 Assert rst after 17 bits and while a word is held -> m_valid=0 immediately; a following 3-bit frame 0b111 with s_last -> m_word=0x7, m_count=3.
REQ-040 Random s_valid/m_ready backpressure over 10^4 bits, checked against a reference queue -> no loss, duplication or reordering, and REQ-026 holds on every stalled cycle.

Source files
------------

// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the serial word loader:
//   LOADER_WIDTH   default assembled word width
//   cnt_width()    width of a bit-count field able to hold 0..width
//   shift_state_e  shift-side state (FILL accepting bits, FULL awaiting output)
// -----------------------------------------------------------------------------
package loader_pkg;

   localparam int LOADER_WIDTH = 32;

   // A count field must represent the value WIDTH itself, hence width+1.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

   typedef enum logic {
      SHIFT_FILL = 1'b0,
      SHIFT_FULL = 1'b1
   } shift_state_e;

endpackage : loader_pkg

// File: rtl/word_out_slice.sv
// -----------------------------------------------------------------------------
// word_out_slice
// Single-entry output register with valid/ready handshake. The parent only
// asserts load_i when the slot is empty or is being drained on this edge.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load_i     write data_i into the slot at this edge
//   data_i     payload to store (DW bits)
//   ready_i    downstream accepts the held payload
//   valid_o    slot holds a payload
//   data_o     held payload, stable while valid_o && !ready_i
// -----------------------------------------------------------------------------
module word_out_slice #(
   parameter int DW = 39
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_i,
   input  logic [DW-1:0] data_i,
   input  logic          ready_i,
   output logic          valid_o,
   output logic [DW-1:0] data_o
);

   logic          valid_q, valid_d;
   logic [DW-1:0] data_q,  data_d;

   always_comb begin
      // NOTE: every combinational output gets a default before any branch, so
      // no path leaves it unassigned and no latch is inferred.
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         // A load on the same edge as a transfer keeps valid high: no bubble.
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples its inputs from before the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule : word_out_slice

// File: rtl/serial_word_loader.sv
// -----------------------------------------------------------------------------
// serial_word_loader
// Assembles an LSB-first serial bit stream into words of up to WIDTH bits.
// A word ends when WIDTH bits have been accepted or on a bit flagged s_last.
// A shift register collects bits; a separate one-entry output register
// (word_out_slice) presents finished words, so one word can be held in each.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   s_valid    serial bit offered        s_ready  loader accepts a bit (registered)
//   s_bit      serial data bit           s_last   bit is the final one of a frame
//   m_valid    word available            m_ready  downstream accepts the word
//   m_word     assembled word, unfilled upper bits zero
//   m_count    number of valid bits in m_word (1..WIDTH)
//   m_short    m_count < WIDTH
// -----------------------------------------------------------------------------
module serial_word_loader
   import loader_pkg::*;
#(
   parameter int WIDTH = LOADER_WIDTH,
   parameter int CNT_W = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             s_bit,
   input  logic             s_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_word,
   output logic [CNT_W-1:0] m_count,
   output logic             m_short
);

   // Output payload layout: {short, count, word}.
   localparam int                DW       = WIDTH + CNT_W + 1;
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WIDTH);

   shift_state_e     state_q,   state_d;
   logic [WIDTH-1:0] shift_q,   shift_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             s_ready_q, s_ready_d;

   logic             bit_accept;
   logic             out_free;
   logic [CNT_W-1:0] cnt_inc;
   logic [WIDTH-1:0] shift_ins;
   logic             word_done;
   logic             load;
   logic [DW-1:0]    load_data;
   logic [DW-1:0]    out_data;

   assign bit_accept = s_valid && s_ready_q;
   // The output slot can take a word if empty or draining on this edge.
   assign out_free   = !m_valid || m_ready;
   assign cnt_inc    = cnt_q + 1'b1;
   // cnt_q < WIDTH whenever a bit is accepted, so the shift stays in range.
   assign shift_ins  = shift_q | ({{(WIDTH-1){1'b0}}, s_bit} << cnt_q);
   assign word_done  = bit_accept && (s_last || (cnt_inc == CNT_FULL));

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      load      = 1'b0;
      load_data = {(cnt_q < CNT_FULL), cnt_q, shift_q};

      unique case (state_q)
         SHIFT_FILL: begin
            if (word_done) begin
               if (out_free) begin
                  // Finished word bypasses the shift register straight into
                  // the output slot; the next bit starts a fresh word.
                  load      = 1'b1;
                  load_data = {(cnt_inc < CNT_FULL), cnt_inc, shift_ins};
                  shift_d   = '0;
                  cnt_d     = '0;
               end else begin
                  // Output slot busy: park the finished word here.
                  state_d = SHIFT_FULL;
                  shift_d = shift_ins;
                  cnt_d   = cnt_inc;
               end
            end else if (bit_accept) begin
               shift_d = shift_ins;
               cnt_d   = cnt_inc;
            end
         end

         SHIFT_FULL: begin
            // The slot is always valid here, so m_ready alone marks a transfer;
            // the parked word replaces it on the same edge.
            if (out_free) begin
               load    = 1'b1;
               state_d = SHIFT_FILL;
               shift_d = '0;
               cnt_d   = '0;
            end
         end

         default: state_d = SHIFT_FILL;
      endcase
   end

   // s_ready is a register of the next shift state, so it never depends
   // combinationally on m_ready.
   assign s_ready_d = (state_d == SHIFT_FILL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= SHIFT_FILL;
         shift_q   <= '0;
         cnt_q     <= '0;
         s_ready_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         s_ready_q <= s_ready_d;
      end
   end

   word_out_slice #(
      .DW (DW)
   ) u_word_out_slice (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load),
      .data_i  (load_data),
      .ready_i (m_ready),
      .valid_o (m_valid),
      .data_o  (out_data)
   );

   assign s_ready = s_ready_q;
   assign m_word  = out_data[WIDTH-1:0];
   assign m_count = out_data[WIDTH +: CNT_W];
   assign m_short = out_data[DW-1];

endmodule : serial_word_loader

// File: tb/tb_serial_word_loader.sv
// -----------------------------------------------------------------------------
// tb_serial_word_loader
// Directed stimulus for serial_word_loader (WIDTH=32) plus a random
// backpressure phase. Expected words are queued by the stimulus and consumed
// by a negedge monitor that also checks output stability while stalled.
// -----------------------------------------------------------------------------
module tb_serial_word_loader;

   localparam int WIDTH = 32;
   localparam int CNT_W = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic             s_valid;
   logic             s_ready;
   logic             s_bit;
   logic             s_last;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_word;
   logic [CNT_W-1:0] m_count;
   logic             m_short;

   serial_word_loader #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_bit   (s_bit),
      .s_last  (s_last),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_word  (m_word),
      .m_count (m_count),
      .m_short (m_short)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] w;
      logic [63:0] c;
      logic [63:0] s;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   rand_mode = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [63:0] w, input logic [63:0] c, input logic [63:0] s);
      exp_q.push_back('{w: w, c: c, s: s});
   endtask

   // Advance to just after the next rising edge.
   task automatic cycle();
      @(posedge clk);
      #1;
      if (rand_mode) m_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send_bit(input logic b, input logic l);
      int n;
      n       = 0;
      s_valid = 1'b1;
      s_bit   = b;
      s_last  = l;
      while (!s_ready && n < 200) begin
         cycle();
         n++;
      end
      if (n >= 200) check("s_ready_timeout", 64'(s_ready), 64'd1);
      cycle();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_word(input logic [63:0] w, input int nbits, input logic last_at_end);
      for (int i = 0; i < nbits; i++)
         send_bit(w[i], last_at_end && (i == nbits - 1));
   endtask

   // Monitor: scoreboard on transfers, stability on stalled cycles.
   initial begin
      exp_t        e;
      bit          prev_stall;
      logic [63:0] prev_w, prev_c, prev_s;
      prev_stall = 1'b0;
      prev_w = '0; prev_c = '0; prev_s = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_valid", 64'(m_valid), 64'd1);
               check("stall_word",  64'(m_word),  prev_w);
               check("stall_count", 64'(m_count), prev_c);
               check("stall_short", 64'(m_short), prev_s);
            end
            if (m_valid && m_ready) begin
               check("word_expected", 64'(exp_q.size() != 0), 64'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("sb_word",  64'(m_word),  e.w);
                  check("sb_count", 64'(m_count), e.c);
                  check("sb_short", 64'(m_short), e.s);
               end
            end
            prev_stall = m_valid && !m_ready;
            prev_w     = 64'(m_word);
            prev_c     = 64'(m_count);
            prev_s     = 64'(m_short);
         end
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] w;
      logic [63:0] cur_w;
      int          cur_c;
      int          n;
      logic        b, l;

      rst = 1'b1; s_valid = 1'b0; s_bit = 1'b0; s_last = 1'b0; m_ready = 1'b0;

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk);
      #1;
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_m_word",  64'(m_word),  64'd0);
      check("rst_m_count", 64'(m_count), 64'd0);
      check("rst_m_short", 64'(m_short), 64'd0);
      check("rst_s_ready", 64'(s_ready), 64'd0);
      rst = 1'b0;
      check("s_ready_before_edge", 64'(s_ready), 64'd0);
      cycle();
      check("s_ready_rise", 64'(s_ready), 64'd1);

      // ---------------- full 32-bit word, s_last on bit 31 ----------------
      m_ready = 1'b1;
      w = 64'hA5A5_F00F;
      push_exp(w, 64'd32, 64'd0);
      for (int i = 0; i < 31; i++) send_bit(w[i], 1'b0);
      check("t35_no_early_valid", 64'(m_valid), 64'd0);
      send_bit(w[31], 1'b1);
      check("t35_valid",  64'(m_valid), 64'd1);
      check("t35_word",   64'(m_word),  64'hA5A5_F00F);
      check("t35_count",  64'(m_count), 64'd32);
      check("t35_short",  64'(m_short), 64'd0);
      cycle();
      check("t35_one_cycle", 64'(m_valid), 64'd0);

      // ---------------- short 5-bit frame ----------------
      push_exp(64'h1D, 64'd5, 64'd1);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b1);
      check("t36_valid", 64'(m_valid), 64'd1);
      check("t36_word",  64'(m_word),  64'h0000_001D);
      check("t36_count", 64'(m_count), 64'd5);
      check("t36_short", 64'(m_short), 64'd1);
      cycle();

      // ---------------- backpressure: second word parks in FULL ----------------
      m_ready = 1'b0;
      push_exp(64'h1234_5678, 64'd32, 64'd0);
      push_exp(64'hCAFE_BABE, 64'd32, 64'd0);
      send_word(64'h1234_5678, 32, 1'b1);
      send_word(64'hCAFE_BABE, 32, 1'b1);
      check("t37_full_s_ready", 64'(s_ready), 64'd0);
      check("t37_hold_word",    64'(m_word),  64'h1234_5678);
      cycle();
      cycle();
      check("t37_still_full", 64'(s_ready), 64'd0);
      m_ready = 1'b1;
      cycle();
      m_ready = 1'b0;
      check("t37_no_bubble",   64'(m_valid), 64'd1);
      check("t37_second_word", 64'(m_word),  64'hCAFE_BABE);
      check("t37_s_ready_back", 64'(s_ready), 64'd1);
      m_ready = 1'b1;
      cycle();
      check("t37_drained", 64'(m_valid), 64'd0);

      // ---------------- 64 bits, no s_last ----------------
      push_exp(64'h0F1E_2D3C, 64'd32, 64'd0);
      push_exp(64'h8000_0001, 64'd32, 64'd0);
      send_word(64'h0F1E_2D3C, 32, 1'b0);
      check("t38_word1",  64'(m_word),  64'h0F1E_2D3C);
      check("t38_short1", 64'(m_short), 64'd0);
      send_word(64'h8000_0001, 32, 1'b0);
      check("t38_word2",  64'(m_word),  64'h8000_0001);
      check("t38_bit32",  64'(m_word[0]), 64'd1);
      check("t38_short2", 64'(m_short), 64'd0);
      cycle();

      // ---------------- reset with a held word and a partial word ----------------
      m_ready = 1'b0;
      send_word(64'h55AA_55AA, 32, 1'b1);
      send_word(64'h1_FFFF, 17, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("t39_valid_cleared", 64'(m_valid), 64'd0);
      check("t39_word_cleared",  64'(m_word),  64'd0);
      check("t39_count_cleared", 64'(m_count), 64'd0);
      check("t39_s_ready_low",   64'(s_ready), 64'd0);
      cycle();
      cycle();
      rst = 1'b0;
      cycle();
      check("t39_s_ready_up",  64'(s_ready), 64'd1);
      check("t39_no_pulse",    64'(m_valid), 64'd0);
      m_ready = 1'b1;
      push_exp(64'h7, 64'd3, 64'd1);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b1);
      check("t39_word",  64'(m_word),  64'h7);
      check("t39_count", 64'(m_count), 64'd3);
      check("t39_short", 64'(m_short), 64'd1);
      cycle();

      // ---------------- random backpressure over 10^4 bits ----------------
      rand_mode = 1'b1;
      cur_w = '0;
      cur_c = 0;
      for (int i = 0; i < 10000; i++) begin
         b = 1'($urandom_range(0, 1));
         l = ($urandom_range(0, 15) == 0) || (i == 9999);
         cur_w[cur_c] = b;
         cur_c++;
         if (l || cur_c == WIDTH) begin
            push_exp(cur_w, 64'(cur_c), 64'(cur_c < WIDTH));
            cur_w = '0;
            cur_c = 0;
         end
         if ($urandom_range(0, 2) == 0) cycle();
         send_bit(b, l);
      end
      rand_mode = 1'b0;
      m_ready   = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         cycle();
         n++;
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_serial_word_loader
